// File: rtl/rename_map_ckpt_pkg.sv
// Shared types, sizes and reset helpers for the rename/checkpoint block.
// Define RENAME_ZERO_REG_EN to make the last architectural register a hardwired zero.
package rename_map_ckpt_pkg;

  localparam int WAYS     = 2;
  localparam int ARF_SIZE = 32;
  localparam int PRF_SIZE = 64;
  localparam int NUM_CKPT = 4;

  localparam int ARF_W  = $clog2(ARF_SIZE);
  localparam int PRF_W  = $clog2(PRF_SIZE);
  localparam int CKPT_W = $clog2(NUM_CKPT);
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef logic [ARF_W-1:0]  arf_idx_t;
  typedef logic [PRF_W-1:0]  prf_idx_t;
  typedef logic [CKPT_W-1:0] ckpt_idx_t;
  typedef logic [WAY_W-1:0]  way_idx_t;
  typedef logic [PRF_W:0]    prf_cnt_t;
  typedef prf_idx_t [ARF_SIZE-1:0] map_t;
  typedef logic [PRF_SIZE-1:0]     free_vec_t;

  function automatic prf_cnt_t popcount(free_vec_t v);
    prf_cnt_t c;
    c = '0;
    for (int i = 0; i < PRF_SIZE; i++) c = c + prf_cnt_t'(v[i]);
    return c;
  endfunction

  function automatic map_t reset_map();
    map_t m;
    for (int i = 0; i < ARF_SIZE; i++) m[i] = prf_idx_t'(i);
    return m;
  endfunction

  function automatic free_vec_t reset_free();
    free_vec_t v;
    v = '0;
    for (int i = ARF_SIZE; i < PRF_SIZE; i++) v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rename_map_ckpt_if.sv
// Decode-side rename bundle, retire frees and branch checkpoint control.
interface rename_map_ckpt_if;
  import rename_map_ckpt_pkg::*;

  logic      [WAYS-1:0] rn_valid;
  arf_idx_t  [WAYS-1:0] rn_opa_arf;
  arf_idx_t  [WAYS-1:0] rn_opb_arf;
  arf_idx_t  [WAYS-1:0] rn_dest_arf;
  logic      [WAYS-1:0] rn_dest_en;
  prf_idx_t  [WAYS-1:0] rn_opa_prf;
  prf_idx_t  [WAYS-1:0] rn_opb_prf;
  prf_idx_t  [WAYS-1:0] rn_dest_prf;
  prf_idx_t  [WAYS-1:0] rn_old_prf;
  logic                 rn_stall;
  logic                 ckpt_req;
  way_idx_t             ckpt_way;
  ckpt_idx_t            ckpt_id;
  logic                 ckpt_full;
  logic      [WAYS-1:0] rt_free_valid;
  prf_idx_t  [WAYS-1:0] rt_free_prf;
  logic                 br_release;
  logic                 br_recover;
  ckpt_idx_t            br_recover_id;
  prf_cnt_t             free_count;

  modport master (
    output rn_valid, rn_opa_arf, rn_opb_arf, rn_dest_arf, rn_dest_en,
    output ckpt_req, ckpt_way, rt_free_valid, rt_free_prf,
    output br_release, br_recover, br_recover_id,
    input  rn_opa_prf, rn_opb_prf, rn_dest_prf, rn_old_prf, rn_stall,
    input  ckpt_id, ckpt_full, free_count
  );

  modport slave (
    input  rn_valid, rn_opa_arf, rn_opb_arf, rn_dest_arf, rn_dest_en,
    input  ckpt_req, ckpt_way, rt_free_valid, rt_free_prf,
    input  br_release, br_recover, br_recover_id,
    output rn_opa_prf, rn_opb_prf, rn_dest_prf, rn_old_prf, rn_stall,
    output ckpt_id, ckpt_full, free_count
  );
endinterface

// File: rtl/rename_map_ckpt_free_list_pick.sv
// Picks the WAYS lowest-numbered free physical registers, in ascending order.
module free_list_pick
  import rename_map_ckpt_pkg::*;
(
  input  free_vec_t            free_vec,
  output prf_idx_t [WAYS-1:0]  pick,
  output logic     [WAYS-1:0]  found
);

  free_vec_t rem;

  always_comb begin
    rem   = free_vec;
    pick  = '0;
    found = '0;
    for (int w = 0; w < WAYS; w++) begin
      // descending scan so the lowest set bit is the last one written
      for (int b = PRF_SIZE - 1; b >= 0; b--) begin
        if (rem[b]) begin
          pick[w]  = prf_idx_t'(b);
          found[w] = 1'b1;
        end
      end
      if (found[w]) rem[pick[w]] = 1'b0;
    end
  end

endmodule

// File: rtl/rename_map_ckpt.sv
// Register rename stage: RAT, PRF free list and branch checkpoints with one-cycle recovery.
// Optional RENAME_ZERO_REG_EN keeps ARF ARF_SIZE-1 permanently mapped to PRF ARF_SIZE-1.
module rename_map_ckpt
  import rename_map_ckpt_pkg::*;
(
  input logic              clock,
  input logic              reset,
  rename_map_ckpt_if.slave rn
);

  map_t      map_q, map_d, map_n, snap_map;
  free_vec_t free_q, free_d, free_n, snap_free, rt_bits;
  prf_cnt_t  fcnt_q;
  map_t      ckpt_map_q  [NUM_CKPT];
  map_t      ckpt_map_d  [NUM_CKPT];
  free_vec_t ckpt_free_q [NUM_CKPT];
  free_vec_t ckpt_free_d [NUM_CKPT];
  logic      [NUM_CKPT-1:0] ckpt_valid_q, ckpt_valid_d;
  ckpt_idx_t head_q, head_d, tail_q, tail_d, rec_age, slot_age;

  prf_idx_t [WAYS-1:0] pick, dest_prf, opa, opb, old;
  logic     [WAYS-1:0] found, alloc, zero_dest;
  logic                short_free, ckpt_block, stall;

  free_list_pick u_pick (
    .free_vec (free_q),
    .pick     (pick),
    .found    (found)
  );

  always_comb begin
    rt_bits = '0;
    for (int w = 0; w < WAYS; w++)
      if (rn.rt_free_valid[w]) rt_bits[rn.rt_free_prf[w]] = 1'b1;
  end

  always_comb begin
    int n;
    n          = 0;
    alloc      = '0;
    zero_dest  = '0;
    dest_prf   = '0;
    opa        = '0;
    opb        = '0;
    old        = '0;
    short_free = 1'b0;
    map_n      = map_q;
    free_n     = free_q;
    snap_map   = map_q;
    snap_free  = free_q;
    for (int i = 0; i < WAYS; i++) begin
`ifdef RENAME_ZERO_REG_EN
      zero_dest[i] = (rn.rn_dest_arf[i] == arf_idx_t'(ARF_SIZE - 1));
`endif
      alloc[i] = rn.rn_valid[i] & rn.rn_dest_en[i] & ~zero_dest[i];
      opa[i]   = map_q[rn.rn_opa_arf[i]];
      opb[i]   = map_q[rn.rn_opb_arf[i]];
      old[i]   = map_q[rn.rn_dest_arf[i]];
      // older ways in the bundle win over the RAT; youngest older writer last
      for (int j = 0; j < i; j++) begin
        if (alloc[j]) begin
          if (rn.rn_dest_arf[j] == rn.rn_opa_arf[i])  opa[i] = dest_prf[j];
          if (rn.rn_dest_arf[j] == rn.rn_opb_arf[i])  opb[i] = dest_prf[j];
          if (rn.rn_dest_arf[j] == rn.rn_dest_arf[i]) old[i] = dest_prf[j];
        end
      end
      if (alloc[i]) begin
        dest_prf[i] = pick[n];
        if (!found[n]) short_free = 1'b1;
        n = n + 1;
        map_n[rn.rn_dest_arf[i]] = dest_prf[i];
        free_n[dest_prf[i]]      = 1'b0;
      end else if (zero_dest[i]) begin
        dest_prf[i] = prf_idx_t'(ARF_SIZE - 1);
      end
      if (way_idx_t'(i) == rn.ckpt_way) begin
        snap_map  = map_n;
        snap_free = free_n;
      end
    end
  end

  // a release in the same cycle frees the head slot for the new checkpoint
  assign ckpt_block = rn.ckpt_req & (&ckpt_valid_q) & ~rn.br_release;
  assign stall      = short_free | ckpt_block | rn.br_recover;

  always_comb begin
    map_d        = map_q;
    free_d       = free_q | rt_bits;
    head_d       = head_q;
    tail_d       = tail_q;
    ckpt_valid_d = ckpt_valid_q;
    rec_age      = rn.br_recover_id - head_q;
    slot_age     = '0;
    for (int s = 0; s < NUM_CKPT; s++) begin
      ckpt_map_d[s]  = ckpt_map_q[s];
      ckpt_free_d[s] = ckpt_free_q[s] | rt_bits;
    end
    if (rn.br_recover) begin
      if (ckpt_valid_q[rn.br_recover_id]) begin
        map_d  = ckpt_map_q[rn.br_recover_id];
        free_d = ckpt_free_q[rn.br_recover_id] | rt_bits;
        tail_d = rn.br_recover_id;
        // drop the restored slot and everything younger than it
        for (int s = 0; s < NUM_CKPT; s++) begin
          slot_age = ckpt_idx_t'(s) - head_q;
          if (slot_age >= rec_age) ckpt_valid_d[s] = 1'b0;
        end
      end
    end else begin
      if (rn.br_release && ckpt_valid_q[head_q]) begin
        ckpt_valid_d[head_q] = 1'b0;
        head_d               = head_q + ckpt_idx_t'(1);
      end
      if (!stall) begin
        map_d  = map_n;
        free_d = free_n | rt_bits;
        if (rn.ckpt_req) begin
          ckpt_map_d[tail_q]   = snap_map;
          ckpt_free_d[tail_q]  = snap_free | rt_bits;
          ckpt_valid_d[tail_q] = 1'b1;
          tail_d               = tail_q + ckpt_idx_t'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      map_q        <= reset_map();
      free_q       <= reset_free();
      fcnt_q       <= prf_cnt_t'(PRF_SIZE - ARF_SIZE);
      ckpt_valid_q <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      for (int s = 0; s < NUM_CKPT; s++) begin
        ckpt_map_q[s]  <= '0;
        ckpt_free_q[s] <= '0;
      end
    end else begin
      map_q        <= map_d;
      free_q       <= free_d;
      fcnt_q       <= popcount(free_d);
      ckpt_valid_q <= ckpt_valid_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      for (int s = 0; s < NUM_CKPT; s++) begin
        ckpt_map_q[s]  <= ckpt_map_d[s];
        ckpt_free_q[s] <= ckpt_free_d[s];
      end
    end
  end

  assign rn.rn_opa_prf  = reset ? '0 : opa;
  assign rn.rn_opb_prf  = reset ? '0 : opb;
  assign rn.rn_dest_prf = reset ? '0 : dest_prf;
  assign rn.rn_old_prf  = reset ? '0 : old;
  assign rn.rn_stall    = stall;
  assign rn.ckpt_id     = tail_q;
  assign rn.ckpt_full   = &ckpt_valid_q;
  assign rn.free_count  = fcnt_q;

endmodule

// File: tb/tb_rename_map_ckpt.sv
// Scoreboarded bench for rename_map_ckpt: hand-derived expectations queued per step.
module tb_rename_map_ckpt;
  import rename_map_ckpt_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  rename_map_ckpt_if rn ();

  rename_map_ckpt dut (
    .clock (clock),
    .reset (reset),
    .rn    (rn)
  );

  typedef enum int {S_OPA, S_OPB, S_DEST, S_OLD, S_STALL, S_CKID, S_FULL, S_FCNT} sel_t;
  typedef struct {
    string tag;
    sel_t  sel;
    int    idx;
    int    exp;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] observe(sel_t s, int i);
    case (s)
      S_OPA:   return 32'(rn.rn_opa_prf[i]);
      S_OPB:   return 32'(rn.rn_opb_prf[i]);
      S_DEST:  return 32'(rn.rn_dest_prf[i]);
      S_OLD:   return 32'(rn.rn_old_prf[i]);
      S_STALL: return 32'(rn.rn_stall);
      S_CKID:  return 32'(rn.ckpt_id);
      S_FULL:  return 32'(rn.ckpt_full);
      default: return 32'(rn.free_count);
    endcase
  endfunction

  task automatic expect_val(string tag, sel_t s, int i, int exp);
    exp_t e;
    e.tag = tag; e.sel = s; e.idx = i; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.tag, observe(e.sel, e.idx), e.exp);
    end
  endtask

  task automatic clear_in();
    rn.rn_valid      = '0;
    rn.rn_opa_arf    = '0;
    rn.rn_opb_arf    = '0;
    rn.rn_dest_arf   = '0;
    rn.rn_dest_en    = '0;
    rn.ckpt_req      = 1'b0;
    rn.ckpt_way      = '0;
    rn.rt_free_valid = '0;
    rn.rt_free_prf   = '0;
    rn.br_release    = 1'b0;
    rn.br_recover    = 1'b0;
    rn.br_recover_id = '0;
  endtask

  task automatic set_way(int w, int dest, int opa, int opb, logic den);
    rn.rn_valid[w]    = 1'b1;
    rn.rn_dest_en[w]  = den;
    rn.rn_dest_arf[w] = arf_idx_t'(dest);
    rn.rn_opa_arf[w]  = arf_idx_t'(opa);
    rn.rn_opb_arf[w]  = arf_idx_t'(opb);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    clear_in();
  endtask

  task automatic do_reset();
    clear_in();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // lookup via way 0 source ports with no destination
  task automatic check_map(string tag, int arf, int exp);
    set_way(0, 0, arf, arf, 1'b0);
    expect_val(tag, S_OPA, 0, exp);
    drain();
    clear_in();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    clear_in();
    // reset state
    #12;
    set_way(0, 0, 5, 5, 1'b0);
    expect_val("rst_tag", S_OPA, 0, 0);
    expect_val("rst_fcnt", S_FCNT, 0, 32);
    expect_val("rst_full", S_FULL, 0, 0);
    expect_val("rst_stall", S_STALL, 0, 0);
    expect_val("rst_ckid", S_CKID, 0, 0);
    drain();
    @(posedge clock);
    #1;
    reset = 1'b0;
    expect_val("lookup_r5", S_OPA, 0, 5);
    drain();
    clear_in();

    // intra-bundle bypass
    set_way(0, 1, 0, 0, 1'b1);
    set_way(1, 1, 1, 2, 1'b1);
    expect_val("byp_dest0", S_DEST, 0, 32);
    expect_val("byp_dest1", S_DEST, 1, 33);
    expect_val("byp_opa1", S_OPA, 1, 32);
    expect_val("byp_opb1", S_OPB, 1, 2);
    expect_val("byp_old0", S_OLD, 0, 1);
    expect_val("byp_old1", S_OLD, 1, 32);
    expect_val("byp_stall", S_STALL, 0, 0);
    drain();
    tick();
    expect_val("byp_fcnt", S_FCNT, 0, 30);
    drain();
    check_map("byp_map_r1", 1, 33);

    // free list exhaustion
    do_reset();
    for (int b = 0; b < 15; b++) begin
      set_way(0, 10, 0, 0, 1'b1);
      set_way(1, 11, 0, 0, 1'b1);
      tick();
    end
    set_way(0, 10, 0, 0, 1'b1);
    tick();
    expect_val("exh_fcnt1", S_FCNT, 0, 1);
    drain();
    set_way(0, 2, 0, 0, 1'b1);
    set_way(1, 3, 0, 0, 1'b1);
    expect_val("exh_stall", S_STALL, 0, 1);
    drain();
    tick();
    check_map("exh_map_r2", 2, 2);
    check_map("exh_map_r3", 3, 3);
    expect_val("exh_fcnt_hold", S_FCNT, 0, 1);
    drain();
    set_way(0, 2, 0, 0, 1'b1);
    expect_val("exh_dest63", S_DEST, 0, 63);
    expect_val("exh_stall1", S_STALL, 0, 0);
    drain();
    tick();
    expect_val("exh_fcnt0", S_FCNT, 0, 0);
    drain();
    check_map("exh_map_r2b", 2, 63);

    // mid-bundle checkpoint and recovery
    do_reset();
    rn.ckpt_req = 1'b1;
    rn.ckpt_way = '0;
    set_way(0, 2, 0, 0, 1'b1);
    set_way(1, 3, 0, 0, 1'b1);
    expect_val("ck_dest0", S_DEST, 0, 32);
    expect_val("ck_dest1", S_DEST, 1, 33);
    expect_val("ck_id0", S_CKID, 0, 0);
    expect_val("ck_stall", S_STALL, 0, 0);
    drain();
    tick();
    expect_val("ck_fcnt30", S_FCNT, 0, 30);
    expect_val("ck_id1", S_CKID, 0, 1);
    drain();
    rn.br_recover    = 1'b1;
    rn.br_recover_id = '0;
    expect_val("rec_stall", S_STALL, 0, 1);
    drain();
    tick();
    check_map("rec_map_r2", 2, 32);
    check_map("rec_map_r3", 3, 3);
    expect_val("rec_fcnt", S_FCNT, 0, 31);
    expect_val("rec_full", S_FULL, 0, 0);
    expect_val("rec_ckid", S_CKID, 0, 0);
    drain();
    set_way(0, 4, 0, 0, 1'b1);
    expect_val("rec_free33", S_DEST, 0, 33);
    drain();
    clear_in();

    // retire free in the recovery cycle
    do_reset();
    rn.ckpt_req = 1'b1;
    expect_val("rt_ckid", S_CKID, 0, 0);
    drain();
    tick();
    set_way(0, 1, 0, 0, 1'b1);
    expect_val("rt_dest", S_DEST, 0, 32);
    expect_val("rt_old", S_OLD, 0, 1);
    drain();
    tick();
    rn.br_recover       = 1'b1;
    rn.br_recover_id    = '0;
    rn.rt_free_valid[0] = 1'b1;
    rn.rt_free_prf[0]   = prf_idx_t'(1);
    tick();
    expect_val("rt_fcnt", S_FCNT, 0, 33);
    drain();
    check_map("rt_map_r1", 1, 1);
    set_way(0, 5, 0, 0, 1'b1);
    expect_val("rt_prf1_free", S_DEST, 0, 1);
    drain();
    clear_in();

    // checkpoint slots full, release+checkpoint, recover and ignored recover
    do_reset();
    rn.br_release = 1'b1;
    tick();
    for (int c = 0; c < NUM_CKPT; c++) begin
      rn.ckpt_req = 1'b1;
      expect_val($sformatf("full_id%0d", c), S_CKID, 0, c);
      expect_val($sformatf("full_stall%0d", c), S_STALL, 0, 0);
      drain();
      tick();
    end
    expect_val("full_set", S_FULL, 0, 1);
    rn.ckpt_req = 1'b1;
    expect_val("full_stall", S_STALL, 0, 1);
    drain();
    tick();
    expect_val("full_hold", S_FULL, 0, 1);
    expect_val("full_id_hold", S_CKID, 0, 0);
    drain();
    rn.ckpt_req   = 1'b1;
    rn.br_release = 1'b1;
    expect_val("relck_stall", S_STALL, 0, 0);
    expect_val("relck_id", S_CKID, 0, 0);
    drain();
    tick();
    expect_val("relck_full", S_FULL, 0, 1);
    expect_val("relck_tail", S_CKID, 0, 1);
    drain();
    rn.br_recover    = 1'b1;
    rn.br_recover_id = ckpt_idx_t'(2);
    tick();
    expect_val("rec2_full", S_FULL, 0, 0);
    expect_val("rec2_tail", S_CKID, 0, 2);
    drain();
    rn.br_recover    = 1'b1;
    rn.br_recover_id = ckpt_idx_t'(3);
    tick();
    expect_val("recinv_tail", S_CKID, 0, 2);
    expect_val("recinv_fcnt", S_FCNT, 0, 32);
    drain();

`ifdef RENAME_ZERO_REG_EN
    do_reset();
    set_way(0, ARF_SIZE - 1, ARF_SIZE - 1, 0, 1'b1);
    expect_val("zr_dest", S_DEST, 0, ARF_SIZE - 1);
    expect_val("zr_old", S_OLD, 0, ARF_SIZE - 1);
    expect_val("zr_src", S_OPA, 0, ARF_SIZE - 1);
    drain();
    tick();
    expect_val("zr_fcnt", S_FCNT, 0, 32);
    drain();
    check_map("zr_map", ARF_SIZE - 1, ARF_SIZE - 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
